memory_arbiter: RTL

Three-port arbiter that shares one single-ported main memory between the processor-ci controller's debug/loader path, the core's instruction fetch port and the core's data port. The core buses are separate, and the shared memory accepts one access at a time, so this block serialises them. It sits between the core bus signals and the memory model inside the controller. Debug access has absolute priority; instruction and data alternate round-robin.

---
 rtl/memory_arbiter_pkg.sv | 17 +
 rtl/arbiter_grant.sv | 28 ++
 rtl/memory_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the three-port memory arbiter.
// Port 0 is the debug/loader path, port 1 instruction fetch, port 2 data.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    localparam int NUM_PORTS  = 3;
    localparam int PORT_DEBUG = 0;
    localparam int PORT_INSTR = 1;
    localparam int PORT_DATA  = 2;

endpackage

// File: rtl/arbiter_grant.sv
// Combinational grant selection: debug port wins outright, instruction and
// data ports alternate using the last-granted flag (last = 1 means data port).
module arbiter_grant
    import memory_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 last,
    output logic [NUM_PORTS-1:0] grant,
    output logic                 valid
);

    always_comb begin
        grant = '0;
        if (req[PORT_DEBUG]) begin
            grant[PORT_DEBUG] = 1'b1;
        end else if (req[PORT_INSTR] && req[PORT_DATA]) begin
            // Tie: the port that did not win last time goes now.
            grant[PORT_INSTR] = last;
            grant[PORT_DATA]  = !last;
        end else if (req[PORT_INSTR]) begin
            grant[PORT_INSTR] = 1'b1;
        end else if (req[PORT_DATA]) begin
            grant[PORT_DATA] = 1'b1;
        end
        valid = |req;
    end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises debug, instruction and data accesses onto one single-ported memory.
// Valid/ready: a requester holds req/we/addr/wdata until it samples ack, then drops req on that edge.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
    output logic [NUM_PORTS-1:0]            ack,
    output logic [NUM_PORTS-1:0]            err,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [ADDR_WIDTH-1:0]           mem_address,
    output logic [DATA_WIDTH-1:0]           mem_write_data,
    input  logic [DATA_WIDTH-1:0]           mem_read_data,
    input  logic                            mem_response,
    output state_t                          fsm_state
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t                  state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic                    we_q, we_d;
    logic                    last_q, last_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_PORTS-1:0]    ack_q, ack_d, err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NUM_PORTS-1:0]    gnt;
    logic                    gnt_valid;
    logic                    done, done_err;
    logic [DATA_WIDTH-1:0]   done_data;

    arbiter_grant u_grant (
        .req   (req),
        .last  (last_q),
        .grant (gnt),
        .valid (gnt_valid)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        we_d      = we_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        ack_d     = '0;
        err_d     = '0;
        rdata_d   = '0;
        done      = 1'b0;
        done_err  = 1'b0;
        done_data = '0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    for (int i = 0; i < NUM_PORTS; i++) begin
                        if (gnt[i]) begin
                            grant_d = 2'(i);
                            we_d    = we[i];
                            addr_d  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                            wdata_d = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    // Debug grants leave the instruction/data rotation untouched.
                    if (!gnt[PORT_DEBUG]) last_d = gnt[PORT_DATA];
                    cnt_d   = '0;
                    rd_d    = !we_d;
                    wr_d    = we_d;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = '0;
                if (mem_response) begin
                    done      = 1'b1;
                    done_data = we_q ? '0 : mem_read_data;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_response) begin
                    done      = 1'b1;
                    done_data = we_q ? '0 : mem_read_data;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CW'(TIMEOUT_CYCLES)) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Completion outputs are registered so they appear in the RESPOND cycle.
        if (done) begin
            state_d = RESPOND;
            ack_d   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_q;
            err_d   = {{(NUM_PORTS-1){1'b0}}, done_err} << grant_q;
            rdata_d = done_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            we_q    <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign ack            = ack_q;
    assign err            = err_q;
    assign rdata          = rdata_q;
    assign mem_read       = rd_q;
    assign mem_write      = wr_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign fsm_state      = state_q;

endmodule
